// File: rtl/fifo_pkt_reader.sv
// Read-side packet parser for the byte FIFO: pops address/length/payload frames,
// routes matching payloads to one of four output ports and drains the rest.
module fifo_pkt_reader #(
    parameter int W_WIDTH = 8,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [4*W_WIDTH-1:0]   addr_cfg,
    input  logic                   fifo_empty,
    input  logic [W_WIDTH-1:0]     fifo_data,
    output logic                   fifo_rd_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W_WIDTH-1:0]     out_data,
    output logic [1:0]             out_port,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [CNT_W-1:0]       pkt_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic                   len_err
);

    typedef enum logic [2:0] {
        IDLE, H_WAIT, L_REQ, L_WAIT, P_REQ, P_WAIT, D_REQ, D_WAIT
    } state_t;

    localparam logic [W_WIDTH-1:0] BYTE_ONE  = {{(W_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [W_WIDTH-1:0] BYTE_ZERO = {W_WIDTH{1'b0}};

    state_t               state_r, state_s;
    logic                 rd_en_s;
    logic                 hit_s;
    logic [1:0]           hit_port_s;
    logic                 match_r;
    logic [1:0]           port_r;
    logic [W_WIDTH-1:0]   cnt_r;
    logic                 first_r;
    logic                 out_valid_r;
    logic [W_WIDTH-1:0]   out_data_r;
    logic [1:0]           out_port_r;
    logic                 out_sop_r;
    logic                 out_eop_r;
    logic [CNT_W-1:0]     pkt_cnt_r;
    logic [CNT_W-1:0]     drop_cnt_r;
    logic                 len_err_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Address match; scanning downwards lets the lowest matching slice win.
    always_comb begin
        hit_s      = 1'b0;
        hit_port_s = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (fifo_data == addr_cfg[i*W_WIDTH +: W_WIDTH]) begin
                hit_s      = 1'b1;
                hit_port_s = i[1:0];
            end else begin
                hit_s      = hit_s;
            end
        end
    end

    // Next-state and FIFO read request; every byte is a REQ/WAIT pair.
    always_comb begin
        state_s = state_r;
        rd_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                rd_en_s = en & ~fifo_empty;
                if (rd_en_s) state_s = H_WAIT;
                else         state_s = IDLE;
            end
            H_WAIT: state_s = L_REQ;
            L_REQ: begin
                rd_en_s = ~fifo_empty;
                if (rd_en_s) state_s = L_WAIT;
                else         state_s = L_REQ;
            end
            L_WAIT: begin
                if (fifo_data == BYTE_ZERO) state_s = IDLE;
                else if (match_r)           state_s = P_REQ;
                else                        state_s = D_REQ;
            end
            P_REQ: begin
                // Only fetch when the output register will be free as the byte lands.
                rd_en_s = ~fifo_empty & (~out_valid_r | out_ready);
                if (rd_en_s) state_s = P_WAIT;
                else         state_s = P_REQ;
            end
            P_WAIT: begin
                if (cnt_r == BYTE_ONE) state_s = IDLE;
                else                   state_s = P_REQ;
            end
            D_REQ: begin
                rd_en_s = ~fifo_empty;
                if (rd_en_s) state_s = D_WAIT;
                else         state_s = D_REQ;
            end
            D_WAIT: begin
                if (cnt_r == BYTE_ONE) state_s = IDLE;
                else                   state_s = D_REQ;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Header capture, byte counter, output register and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_r     <= 1'b0;
            port_r      <= 2'd0;
            cnt_r       <= BYTE_ZERO;
            first_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= BYTE_ZERO;
            out_port_r  <= 2'd0;
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            pkt_cnt_r   <= {CNT_W{1'b0}};
            drop_cnt_r  <= {CNT_W{1'b0}};
            len_err_r   <= 1'b0;
        end else begin
            len_err_r <= 1'b0;
            if (out_valid_r && out_ready) out_valid_r <= 1'b0;
            case (state_r)
                H_WAIT: begin
                    match_r <= hit_s;
                    port_r  <= hit_port_s;
                end
                L_WAIT: begin
                    cnt_r   <= fifo_data;
                    first_r <= 1'b1;
                    if (fifo_data == BYTE_ZERO) begin
                        len_err_r  <= 1'b1;
                        drop_cnt_r <= sat_inc(drop_cnt_r);
                    end else if (!match_r) begin
                        drop_cnt_r <= sat_inc(drop_cnt_r);
                    end
                end
                P_WAIT: begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= fifo_data;
                    out_port_r  <= port_r;
                    out_sop_r   <= first_r;
                    out_eop_r   <= (cnt_r == BYTE_ONE);
                    first_r     <= 1'b0;
                    cnt_r       <= cnt_r - BYTE_ONE;
                    if (cnt_r == BYTE_ONE) pkt_cnt_r <= sat_inc(pkt_cnt_r);
                end
                D_WAIT: cnt_r <= cnt_r - BYTE_ONE;
                default: ;
            endcase
        end
    end

    assign fifo_rd_en = rd_en_s & ~rst;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_port   = out_port_r;
    assign out_sop    = out_sop_r;
    assign out_eop    = out_eop_r;
    assign pkt_cnt    = pkt_cnt_r;
    assign drop_cnt   = drop_cnt_r;
    assign len_err    = len_err_r;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: a byte-FIFO model feeds framed packets and a
// packet-level model predicts output beats, counters and len_err pulses.
module tb_fifo_pkt_reader;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] p;
        logic       s;
        logic       e;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] addr_cfg = 32'h0;
    logic        fifo_empty;
    logic [7:0]  fifo_data = 8'h0;
    logic        fifo_rd_en;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [1:0]  out_port;
    logic        out_sop, out_eop;
    logic [15:0] pkt_cnt, drop_cnt;
    logic        len_err;
    // Narrow-counter twin: same stimulus, reaches saturation in a few packets.
    logic        n_rd_en, n_valid, n_sop, n_eop, n_len_err;
    logic [7:0]  n_data;
    logic [1:0]  n_port;
    logic [2:0]  n_pkt, n_drop;

    fifo_pkt_reader #(.W_WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .addr_cfg(addr_cfg),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_port(out_port), .out_sop(out_sop), .out_eop(out_eop),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .len_err(len_err));

    fifo_pkt_reader #(.W_WIDTH(8), .CNT_W(3)) dut_n (
        .clk(clk), .rst(rst), .en(en), .addr_cfg(addr_cfg),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(n_rd_en),
        .out_valid(n_valid), .out_ready(out_ready), .out_data(n_data),
        .out_port(n_port), .out_sop(n_sop), .out_eop(n_eop),
        .pkt_cnt(n_pkt), .drop_cnt(n_drop), .len_err(n_len_err));

    always #5 clk = ~clk;

    // FIFO model
    logic [7:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       fifo_flush = 1'b0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Packet-level model state
    beat_t      exp_q[$];
    logic [7:0] pl_q[$];
    logic [7:0] cfg_b [4];
    int exp_pkt = 0, exp_drop = 0, exp_lerr = 0, lerr_seen = 0;
    int compared = 0, mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] c3, c2, c1, c0);
        cfg_b[3] = c3; cfg_b[2] = c2; cfg_b[1] = c1; cfg_b[0] = c0;
        addr_cfg = {c3, c2, c1, c0};
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    // Predict the outcome of one frame from the routing rules, then queue its bytes.
    task automatic send(input logic [7:0] a, input int n);
        int m;
        m = -1;
        for (int i = 0; i < 4; i++)
            if (m < 0 && cfg_b[i] == a) m = i;
        if (n == 0) begin
            exp_lerr++;
            exp_drop++;
        end else if (m < 0) begin
            exp_drop++;
        end else begin
            for (int i = 0; i < n; i++)
                exp_q.push_back(beat_t'{pl_q[i], m[1:0], (i == 0), (i == n - 1)});
            exp_pkt++;
        end
        push_byte(a);
        push_byte(n[7:0]);
        for (int i = 0; i < n; i++) push_byte(pl_q[i]);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((!fifo_empty || exp_q.size() != 0) && b < 300) begin
            tick();
            b++;
        end
        if (b >= 300) chk("drain_timeout", 32'd1, 32'd0);
        repeat (6) tick();
    endtask

    task automatic chk_counts();
        chk("pkt_cnt", pkt_cnt, sat(exp_pkt, 16));
        chk("drop_cnt", drop_cnt, sat(exp_drop, 16));
        chk("pkt_cnt_narrow", n_pkt, sat(exp_pkt, 3));
        chk("drop_cnt_narrow", n_drop, sat(exp_drop, 3));
        chk("len_err_pulses", lerr_seen, exp_lerr);
    endtask

    task automatic wait_byte(input logic [7:0] b);
        int k;
        k = 0;
        while (!(out_valid && out_data == b) && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) chk("wait_byte_timeout", 32'd1, 32'd0);
    endtask

    // Per-cycle compare process: read safety, hold-while-stalled, beat order, len_err shape.
    logic        hold_r = 1'b0;
    logic        prev_lerr = 1'b0;
    logic [12:0] held = 13'h0;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold_r    = 1'b0;
            prev_lerr = 1'b0;
        end else begin
            chk("rd_en_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
            if (hold_r)
                chk("hold_stalled", {out_valid, out_data, out_port, out_sop, out_eop}, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {out_data, out_port, out_sop, out_eop}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {out_data, out_port, out_sop, out_eop}, e);
                end
            end
            if (len_err) begin
                lerr_seen++;
                chk("len_err_single", {31'd0, prev_lerr}, 32'd0);
            end
            prev_lerr = len_err;
            hold_r    = out_valid & ~out_ready;
            held      = {out_valid, out_data, out_port, out_sop, out_eop};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rp;
        // Reset: outputs clear and no reads even with data present and en high.
        push_byte(8'hEE);
        en = 1'b1;
        repeat (2) tick();
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_outputs", {out_valid, out_data, out_port, out_sop, out_eop, len_err}, 32'd0);
        chk("rst_pkt_cnt", pkt_cnt, 32'd0);
        chk("rst_drop_cnt", drop_cnt, 32'd0);
        fifo_flush = 1'b1;
        tick();
        fifo_flush = 1'b0;
        rst = 1'b0;

        // 1: basic packet to port 1
        set_cfg(8'h40, 8'h30, 8'h20, 8'h10);
        pl_q = '{8'hAA, 8'hBB, 8'hCC};
        send(8'h20, 3);
        drain();
        chk("t1_pkt_lit", pkt_cnt, 32'd1);
        chk("t1_last_lit", {out_data, out_port, out_sop, out_eop}, {8'hCC, 2'd1, 1'b0, 1'b1});
        chk_counts();

        // 2: unmatched packet drained, then single-byte packet to port 3
        pl_q = '{8'h01, 8'h02};
        send(8'h77, 2);
        drain();
        chk("t2_drop_lit", drop_cnt, 32'd1);
        chk("t2_no_beat_pkt", pkt_cnt, 32'd1);
        pl_q = '{8'h5A};
        send(8'h40, 1);
        drain();
        chk("t2_last_lit", {out_data, out_port, out_sop, out_eop}, {8'h5A, 2'd3, 1'b1, 1'b1});
        chk_counts();

        // 3: back-pressure on byte 2
        pl_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        send(8'h10, 4);
        wait_byte(8'h02);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall_data", {out_valid, out_data}, {1'b1, 8'h02});
            chk("t3_stall_no_read", {31'd0, fifo_rd_en}, 32'd0);
        end
        out_ready = 1'b1;
        drain();
        chk_counts();

        // 4: zero-length header, then valid packet on port 0
        pl_q = '{8'hEE};
        send(8'h10, 0);
        send(8'h10, 1);
        drain();
        chk("t4_lerr_lit", lerr_seen, 32'd1);
        chk("t4_drop_lit", drop_cnt, 32'd2);
        chk("t4_last_lit", {out_data, out_port}, {8'hEE, 2'd0});
        chk_counts();

        // 5: duplicate addresses, lowest slice wins
        set_cfg(8'h40, 8'h55, 8'h55, 8'h10);
        pl_q = '{8'h99};
        send(8'h55, 1);
        drain();
        chk("t5_port_lit", {out_data, out_port}, {8'h99, 2'd1});
        chk_counts();

        // 6: reset during the second payload byte
        set_cfg(8'h40, 8'h30, 8'h20, 8'h10);
        exp_q.push_back(beat_t'{8'h11, 2'd2, 1'b1, 1'b0});
        push_byte(8'h30); push_byte(8'h03);
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        wait_byte(8'h22);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("t6_first_beat_seen", exp_q.size(), 32'd0);
        fifo_flush = 1'b1;
        tick();
        fifo_flush = 1'b0;
        rst = 1'b0;
        exp_pkt = 0;
        exp_drop = 0;
        chk_counts();
        pl_q = '{8'h61, 8'h62};
        send(8'h30, 2);
        drain();
        chk_counts();

        // en low blocks header fetch
        en = 1'b0;
        rp = rd_ptr;
        pl_q = '{8'h5A};
        send(8'h10, 1);
        repeat (6) tick();
        chk("en_low_no_read", rd_ptr, rp);
        chk("en_low_no_valid", {31'd0, out_valid}, 32'd0);
        en = 1'b1;
        drain();
        chk_counts();

        // 7: counter saturation (narrow twin saturates at 7)
        for (int i = 0; i < 8; i++) begin
            pl_q = '{i[7:0]};
            send(8'h20, 1);
        end
        drain();
        chk("t7_narrow_sat_lit", n_pkt, 32'd7);
        chk("t7_wide_lit", pkt_cnt, 32'd10);
        chk_counts();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
